// File: rtl/cmt_pkg.sv
// Shared definitions for the multi-lane difftest commit unit: record widths,
// trap constants and FSM encoding.
package cmt_pkg;

  localparam logic [6:0] TRAP_OPC_DEF  = 7'h6b;
  localparam logic [7:0] WDOG_CODE_DEF = 8'hff;

  localparam int PC_W    = 64;
  localparam int INST_W  = 32;
  localparam int DATA_W  = 64;
  localparam int WDEST_W = 8;
  localparam int CODE_W  = 8;
  localparam int CNT_W   = 64;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } cmt_state_e;

  // Index width for an n-entry lane vector, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmt_compact.sv
// Combinational priority compactor: the j-th set input bit (from lane 0)
// selects output lane j. Also yields an exclusive prefix-OR of the input.
module cmt_compact
  import cmt_pkg::*;
#(
  parameter int N     = 2,
  parameter int SEL_W = idx_w(N)
) (
  input  logic [N-1:0]       i_valid,
  output logic [N*SEL_W-1:0] o_sel,
  output logic [N-1:0]       o_sel_vld,
  output logic [N-1:0]       o_prefix_excl
);

  localparam int RANK_W = $clog2(N + 1);

  logic [RANK_W-1:0] rank;
  logic              seen;

  // NOTE: every variable written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    o_sel         = '0;
    o_sel_vld     = '0;
    o_prefix_excl = '0;
    rank          = '0;
    seen          = 1'b0;
    for (int i = 0; i < N; i++) begin
      o_prefix_excl[i] = seen;
      seen             = seen | i_valid[i];
      if (i_valid[i]) begin
        for (int j = 0; j < N; j++) begin
          if (rank == RANK_W'(j)) begin
            o_sel[j*SEL_W +: SEL_W] = SEL_W'(i);
            o_sel_vld[j]            = 1'b1;
          end
        end
        rank = rank + RANK_W'(1);
      end
    end
  end

endmodule

// File: rtl/cmt_multi.sv
// Multi-lane difftest commit unit: trap-masks and compacts retiring lanes,
// keeps cycle/instr/skip counters and a watchdog; state updates on negedge.
module cmt_multi
  import cmt_pkg::*;
#(
  parameter int         NCMT      = 2,
  parameter int         RIDX_W    = 5,
  parameter int         TIMEOUT   = 4096,
  parameter logic [6:0] TRAP_OPC  = TRAP_OPC_DEF,
  parameter logic [7:0] WDOG_CODE = WDOG_CODE_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCMT-1:0]           i_valid,
  input  logic [NCMT*PC_W-1:0]      i_pc,
  input  logic [NCMT*INST_W-1:0]    i_inst,
  input  logic [NCMT*RIDX_W-1:0]    i_rd,
  input  logic [NCMT-1:0]           i_rd_wen,
  input  logic [NCMT*DATA_W-1:0]    i_rd_wdata,
  input  logic [NCMT-1:0]           i_skip,
  input  logic [63:0]               i_a0,
  output logic [NCMT-1:0]           o_valid,
  output logic [NCMT*PC_W-1:0]      o_pc,
  output logic [NCMT*INST_W-1:0]    o_inst,
  output logic [NCMT-1:0]           o_wen,
  output logic [NCMT*WDEST_W-1:0]   o_wdest,
  output logic [NCMT*DATA_W-1:0]    o_wdata,
  output logic [NCMT-1:0]           o_skip,
  output logic                      o_trap,
  output logic [CODE_W-1:0]         o_trap_code,
  output logic [PC_W-1:0]           o_trap_pc,
  output logic [CNT_W-1:0]          o_cycle_cnt,
  output logic [CNT_W-1:0]          o_instr_cnt,
  output logic [CNT_W-1:0]          o_skip_cnt
);

  localparam int SEL_W  = idx_w(NCMT);
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  function automatic logic [CNT_W-1:0] popcnt(input logic [NCMT-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NCMT; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  cmt_state_e               state_q, state_d;
  logic [NCMT-1:0]          valid_q, valid_d, wen_q, wen_d, skip_q, skip_d;
  logic [NCMT*PC_W-1:0]     pc_q, pc_d;
  logic [NCMT*INST_W-1:0]   inst_q, inst_d;
  logic [NCMT*WDEST_W-1:0]  wdest_q, wdest_d;
  logic [NCMT*DATA_W-1:0]   wdata_q, wdata_d;
  logic                     trap_q, trap_d;
  logic [CODE_W-1:0]        trap_code_q, trap_code_d;
  logic [PC_W-1:0]          trap_pc_q, trap_pc_d, last_pc_q, last_pc_d;
  logic [CNT_W-1:0]         cycle_q, cycle_d, instr_q, instr_d, skipc_q, skipc_d;
  logic [IDLE_W-1:0]        idle_q, idle_d, idle_inc;

  logic [NCMT-1:0]          trap_hit, trap_excl, trap_vld, eff_valid;
  logic [NCMT-1:0]          lane_vld, lane_excl;
  logic [NCMT*SEL_W-1:0]    trap_sel_all, lane_sel;
  logic [SEL_W-1:0]         trap_sel, src;
  logic                     unused_bits;

  always_comb begin
    for (int i = 0; i < NCMT; i++)
      trap_hit[i] = i_valid[i] && (i_inst[i*INST_W +: 7] == TRAP_OPC);
  end

  // The same compactor finds the oldest trap lane and masks everything younger.
  cmt_compact #(.N(NCMT), .SEL_W(SEL_W)) u_trap (
    .i_valid       (trap_hit),
    .o_sel         (trap_sel_all),
    .o_sel_vld     (trap_vld),
    .o_prefix_excl (trap_excl)
  );

  assign eff_valid = i_valid & ~trap_excl;
  assign trap_sel  = trap_sel_all[SEL_W-1:0];

  cmt_compact #(.N(NCMT), .SEL_W(SEL_W)) u_lane (
    .i_valid       (eff_valid),
    .o_sel         (lane_sel),
    .o_sel_vld     (lane_vld),
    .o_prefix_excl (lane_excl)
  );

  assign unused_bits = ^{trap_sel_all, trap_vld, lane_excl, i_a0[63:8]};
  assign idle_inc    = idle_q + IDLE_W'(1);

  always_comb begin
    state_d     = state_q;
    valid_d     = '0;
    pc_d        = '0;
    inst_d      = '0;
    wen_d       = '0;
    wdest_d     = '0;
    wdata_d     = '0;
    skip_d      = '0;
    trap_d      = trap_q;
    trap_code_d = trap_code_q;
    trap_pc_d   = trap_pc_q;
    last_pc_d   = last_pc_q;
    cycle_d     = cycle_q;
    instr_d     = instr_q;
    skipc_d     = skipc_q;
    idle_d      = idle_q;
    src         = '0;
    if (state_q == ST_RUN) begin
      for (int j = 0; j < NCMT; j++) begin
        if (lane_vld[j]) begin
          src                          = lane_sel[j*SEL_W +: SEL_W];
          valid_d[j]                   = 1'b1;
          pc_d[j*PC_W +: PC_W]         = i_pc[src*PC_W +: PC_W];
          inst_d[j*INST_W +: INST_W]   = i_inst[src*INST_W +: INST_W];
          wen_d[j]                     = i_rd_wen[src];
          wdest_d[j*WDEST_W +: WDEST_W] = WDEST_W'(i_rd[src*RIDX_W +: RIDX_W]);
          wdata_d[j*DATA_W +: DATA_W]  = i_rd_wdata[src*DATA_W +: DATA_W];
          skip_d[j]                    = i_skip[src];
          last_pc_d                    = i_pc[src*PC_W +: PC_W];
        end
      end
      cycle_d = cycle_q + CNT_W'(1);
      instr_d = instr_q + popcnt(eff_valid);
      skipc_d = skipc_q + popcnt(eff_valid & i_skip);
      if (TIMEOUT == 0 || |eff_valid) idle_d = '0;
      else                            idle_d = idle_inc;
      if (trap_hit != '0) begin
        trap_d      = 1'b1;
        trap_code_d = i_a0[CODE_W-1:0];
        trap_pc_d   = i_pc[trap_sel*PC_W +: PC_W];
        state_d     = ST_TRAP;
      end else if (TIMEOUT > 0 && eff_valid == '0 && idle_inc == IDLE_W'(TIMEOUT)) begin
        trap_d      = 1'b1;
        trap_code_d = WDOG_CODE;
        trap_pc_d   = last_pc_q;
        state_d     = ST_TRAP;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      valid_q     <= '0;
      pc_q        <= '0;
      inst_q      <= '0;
      wen_q       <= '0;
      wdest_q     <= '0;
      wdata_q     <= '0;
      skip_q      <= '0;
      trap_q      <= 1'b0;
      trap_code_q <= '0;
      trap_pc_q   <= '0;
      last_pc_q   <= '0;
      cycle_q     <= '0;
      instr_q     <= '0;
      skipc_q     <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      wen_q       <= wen_d;
      wdest_q     <= wdest_d;
      wdata_q     <= wdata_d;
      skip_q      <= skip_d;
      trap_q      <= trap_d;
      trap_code_q <= trap_code_d;
      trap_pc_q   <= trap_pc_d;
      last_pc_q   <= last_pc_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
      skipc_q     <= skipc_d;
      idle_q      <= idle_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_pc        = pc_q;
  assign o_inst      = inst_q;
  assign o_wen       = wen_q;
  assign o_wdest     = wdest_q;
  assign o_wdata     = wdata_q;
  assign o_skip      = skip_q;
  assign o_trap      = trap_q;
  assign o_trap_code = trap_code_q;
  assign o_trap_pc   = trap_pc_q;
  assign o_cycle_cnt = cycle_q;
  assign o_instr_cnt = instr_q;
  assign o_skip_cnt  = skipc_q;

endmodule

// File: tb/tb_cmt_multi.sv
// Directed bench for cmt_multi: a 2-lane instance with an 8-cycle watchdog
// and a 4-lane instance with the watchdog disabled.
module tb_cmt_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // 2-lane instance
  logic [1:0]   v2, wen2, sk2;
  logic [127:0] pc2, wd2;
  logic [63:0]  inst2, a0_2;
  logic [9:0]   rd2;
  logic [1:0]   ov2, owen2, osk2;
  logic [127:0] opc2, owd2;
  logic [63:0]  oinst2;
  logic [15:0]  odest2;
  logic         otrap2;
  logic [7:0]   ocode2;
  logic [63:0]  otpc2, ocyc2, oins2, oskc2;

  cmt_multi #(.NCMT(2), .TIMEOUT(8)) dut2 (
    .clk(clk), .rst(rst), .i_valid(v2), .i_pc(pc2), .i_inst(inst2), .i_rd(rd2),
    .i_rd_wen(wen2), .i_rd_wdata(wd2), .i_skip(sk2), .i_a0(a0_2),
    .o_valid(ov2), .o_pc(opc2), .o_inst(oinst2), .o_wen(owen2), .o_wdest(odest2),
    .o_wdata(owd2), .o_skip(osk2), .o_trap(otrap2), .o_trap_code(ocode2),
    .o_trap_pc(otpc2), .o_cycle_cnt(ocyc2), .o_instr_cnt(oins2), .o_skip_cnt(oskc2)
  );

  // 4-lane instance
  logic [3:0]   v4, wen4, sk4;
  logic [255:0] pc4, wd4;
  logic [127:0] inst4;
  logic [19:0]  rd4;
  logic [63:0]  a0_4;
  logic [3:0]   ov4, owen4, osk4;
  logic [255:0] opc4, owd4;
  logic [127:0] oinst4;
  logic [31:0]  odest4;
  logic         otrap4;
  logic [7:0]   ocode4;
  logic [63:0]  otpc4, ocyc4, oins4, oskc4;

  cmt_multi #(.NCMT(4), .TIMEOUT(0)) dut4 (
    .clk(clk), .rst(rst), .i_valid(v4), .i_pc(pc4), .i_inst(inst4), .i_rd(rd4),
    .i_rd_wen(wen4), .i_rd_wdata(wd4), .i_skip(sk4), .i_a0(a0_4),
    .o_valid(ov4), .o_pc(opc4), .o_inst(oinst4), .o_wen(owen4), .o_wdest(odest4),
    .o_wdata(owd4), .o_skip(osk4), .o_trap(otrap4), .o_trap_code(ocode4),
    .o_trap_pc(otpc4), .o_cycle_cnt(ocyc4), .o_instr_cnt(oins4), .o_skip_cnt(oskc4)
  );

  task automatic clear_inputs();
    v2 = '0; wen2 = '0; sk2 = '0; pc2 = '0; wd2 = '0; inst2 = '0; a0_2 = '0; rd2 = '0;
    v4 = '0; wen4 = '0; sk4 = '0; pc4 = '0; wd4 = '0; inst4 = '0; a0_4 = '0; rd4 = '0;
  endtask

  // Outputs change on the falling edge; sample 1 time unit later.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    checks++; if (ov2 !== 2'b00 || otrap2 !== 1'b0) begin errors++; $display("FAIL reset_valid_trap: got %b/%b want 00/0", ov2, otrap2); end
    checks++; if (ocyc2 !== 64'd0 || oins2 !== 64'd0 || oskc2 !== 64'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", ocyc2, oins2, oskc2); end
    checks++; if (ocode2 !== 8'd0 || otpc2 !== 64'd0 || opc2 !== 128'd0) begin errors++; $display("FAIL reset_trap_fields: got code=%h pc=%h want 0", ocode2, otpc2); end
    rst = 1'b0;
  endtask

  task automatic test_two_lane();
    do_reset();
    v2 = 2'b11;
    pc2[63:0] = 64'h8000_0000; pc2[127:64] = 64'h8000_0004;
    inst2[31:0] = 32'h0000_0013; inst2[63:32] = 32'h0000_0013;
    rd2[9:5] = 5'd5; wen2 = 2'b10; wd2[127:64] = 64'h1234;
    tick();
    checks++; if (ov2 !== 2'b11) begin errors++; $display("FAIL two_lane_valid: got %b want 11", ov2); end
    checks++; if (odest2[15:8] !== 8'h05 || owen2 !== 2'b10) begin errors++; $display("FAIL two_lane_wdest: got %h wen=%b want 05 wen=10", odest2[15:8], owen2); end
    checks++; if (opc2[127:64] !== 64'h8000_0004 || owd2[127:64] !== 64'h1234) begin errors++; $display("FAIL two_lane_data: got pc=%h wd=%h want 80000004/1234", opc2[127:64], owd2[127:64]); end
    checks++; if (oins2 !== 64'd2 || ocyc2 !== 64'd1) begin errors++; $display("FAIL two_lane_counts: got instr=%0d cycle=%0d want 2/1", oins2, ocyc2); end
  endtask

  task automatic test_gapped();
    do_reset();
    v4 = 4'b1010;
    pc4[64*1 +: 64] = 64'h100; pc4[64*3 +: 64] = 64'h200;
    tick();
    checks++; if (ov4 !== 4'b0011) begin errors++; $display("FAIL gapped_valid: got %b want 0011", ov4); end
    checks++; if (opc4[63:0] !== 64'h100 || opc4[127:64] !== 64'h200) begin errors++; $display("FAIL gapped_pc: got %h/%h want 100/200", opc4[63:0], opc4[127:64]); end
    checks++; if (opc4[255:128] !== 128'd0) begin errors++; $display("FAIL gapped_upper_zero: got %h want 0", opc4[255:128]); end
    clear_inputs();
    v4 = 4'b0100; pc4[64*2 +: 64] = 64'h300; wen4 = 4'b0100; rd4[14:10] = 5'd7;
    tick();
    checks++; if (ov4 !== 4'b0001 || opc4[63:0] !== 64'h300) begin errors++; $display("FAIL single_lane2: got v=%b pc=%h want 0001/300", ov4, opc4[63:0]); end
    checks++; if (owen4 !== 4'b0001 || odest4[7:0] !== 8'h07) begin errors++; $display("FAIL single_lane2_wen: got %b/%h want 0001/07", owen4, odest4[7:0]); end
    checks++; if (oins4 !== 64'd3 || ocyc4 !== 64'd2) begin errors++; $display("FAIL gapped_counts: got %0d/%0d want 3/2", oins4, ocyc4); end
  endtask

  task automatic test_trap();
    do_reset();
    v2 = 2'b11; inst2[31:0] = 32'h0000_006b; inst2[63:32] = 32'h0000_0013;
    pc2[63:0] = 64'h1000; pc2[127:64] = 64'h1004; a0_2 = 64'h0;
    tick();
    checks++; if (otrap2 !== 1'b1 || ocode2 !== 8'h00 || otpc2 !== 64'h1000) begin errors++; $display("FAIL trap_entry: got t=%b code=%h pc=%h want 1/00/1000", otrap2, ocode2, otpc2); end
    checks++; if (ov2 !== 2'b01 || oins2 !== 64'd1) begin errors++; $display("FAIL trap_mask: got v=%b instr=%0d want 01/1", ov2, oins2); end
    inst2[31:0] = 32'h0000_0013; a0_2 = 64'h55; pc2[63:0] = 64'h2000;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ov2 !== 2'b00 || oins2 !== 64'd1 || ocyc2 !== 64'd1) begin errors++; $display("FAIL trap_frozen: got v=%b instr=%0d cycle=%0d want 00/1/1", ov2, oins2, ocyc2); end
      checks++; if (otrap2 !== 1'b1 || ocode2 !== 8'h00 || otpc2 !== 64'h1000) begin errors++; $display("FAIL trap_hold: got %b/%h/%h want 1/00/1000", otrap2, ocode2, otpc2); end
    end
    // Trap in the younger lane: both lanes commit, code from a0.
    do_reset();
    v2 = 2'b11; inst2[31:0] = 32'h0000_0013; inst2[63:32] = 32'h0000_006b;
    pc2[63:0] = 64'h4000; pc2[127:64] = 64'h4004; a0_2 = 64'h101;
    tick();
    checks++; if (otrap2 !== 1'b1 || ocode2 !== 8'h01 || otpc2 !== 64'h4004 || ov2 !== 2'b11) begin errors++; $display("FAIL trap_lane1: got t=%b code=%h pc=%h v=%b want 1/01/4004/11", otrap2, ocode2, otpc2, ov2); end
  endtask

  task automatic test_watchdog();
    do_reset();
    v2 = 2'b01; pc2[63:0] = 64'h2000;
    tick();
    clear_inputs();
    for (int k = 0; k < 7; k++) tick();
    checks++; if (otrap2 !== 1'b0) begin errors++; $display("FAIL wdog_early: got %b want 0", otrap2); end
    tick();
    checks++; if (otrap2 !== 1'b1 || ocode2 !== 8'hff || otpc2 !== 64'h2000) begin errors++; $display("FAIL wdog_fire: got t=%b code=%h pc=%h want 1/ff/2000", otrap2, ocode2, otpc2); end
    tick();
    checks++; if (ocyc2 !== 64'd9) begin errors++; $display("FAIL wdog_cycle_hold: got %0d want 9", ocyc2); end
    // A trap instruction on the expiring edge reports its own code.
    do_reset();
    v2 = 2'b01; pc2[63:0] = 64'h2000;
    tick();
    clear_inputs();
    for (int k = 0; k < 7; k++) tick();
    v2 = 2'b01; inst2[31:0] = 32'h0000_006b; pc2[63:0] = 64'h3000; a0_2 = 64'h133;
    tick();
    checks++; if (otrap2 !== 1'b1 || ocode2 !== 8'h33 || otpc2 !== 64'h3000 || oins2 !== 64'd2) begin errors++; $display("FAIL trap_beats_wdog: got t=%b code=%h pc=%h instr=%0d want 1/33/3000/2", otrap2, ocode2, otpc2, oins2); end
  endtask

  task automatic test_skip();
    do_reset();
    v2 = 2'b11; sk2 = 2'b11;
    tick();
    checks++; if (osk2 !== 2'b11) begin errors++; $display("FAIL skip_both: got %b want 11", osk2); end
    sk2 = 2'b00;
    tick();
    checks++; if (osk2 !== 2'b00) begin errors++; $display("FAIL skip_none: got %b want 00", osk2); end
    v2 = 2'b10; sk2 = 2'b10;
    tick();
    checks++; if (osk2 !== 2'b01 || ov2 !== 2'b01) begin errors++; $display("FAIL skip_compact: got sk=%b v=%b want 01/01", osk2, ov2); end
    checks++; if (oins2 !== 64'd5 || oskc2 !== 64'd3) begin errors++; $display("FAIL skip_counts: got %0d/%0d want 5/3", oins2, oskc2); end
  endtask

  task automatic test_async_reset();
    do_reset();
    v2 = 2'b11; pc2[63:0] = 64'h10;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (ov2 !== 2'b00 || ocyc2 !== 64'd0 || oins2 !== 64'd0 || opc2 !== 128'd0) begin errors++; $display("FAIL async_rst_run: got v=%b cyc=%0d instr=%0d want 0", ov2, ocyc2, oins2); end
    rst = 1'b0;
    clear_inputs();
    v2 = 2'b01; inst2[31:0] = 32'h0000_006b; pc2[63:0] = 64'h50; a0_2 = 64'h7;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (otrap2 !== 1'b0 || ocode2 !== 8'd0 || otpc2 !== 64'd0) begin errors++; $display("FAIL async_rst_trap: got t=%b code=%h pc=%h want 0", otrap2, ocode2, otpc2); end
    rst = 1'b0;
    clear_inputs();
    v2 = 2'b01; pc2[63:0] = 64'h60;
    tick();
    checks++; if (ov2 !== 2'b01 || ocyc2 !== 64'd1 || oins2 !== 64'd1 || otrap2 !== 1'b0) begin errors++; $display("FAIL post_rst_resume: got v=%b cyc=%0d instr=%0d t=%b want 01/1/1/0", ov2, ocyc2, oins2, otrap2); end
  endtask

  initial begin
    test_reset();
    test_two_lane();
    test_gapped();
    test_trap();
    test_watchdog();
    test_skip();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no completion want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/cmt_multi.md
Name: cmt_multi

Overview:
- Parametrised commit unit for difftest.
- Accepts up to NCMT retiring instructions per cycle from the writeback stage.
- Compacts the valid lanes so that the committed records occupy output lanes 0..k-1 in program order.
- Detects the trap instruction and freezes itself afterwards. Keeps cycle, instruction and skip counters, and raises a watchdog trap when no commit occurs for TIMEOUT cycles.
- Its registered outputs drive the DifftestInstrCommit instances (one per lane) and the DifftestTrapEvent instance.

Parameters:
- NCMT, 2, number of commit lanes (1..4); lane 0 is oldest in program order.
- RIDX_W, 5, register index width.
- TIMEOUT, 4096, idle cycles without a valid commit before a watchdog trap; 0 disables the watchdog.
- TRAP_OPC, 7'h6b, opcode that marks the good/bad trap instruction.
- WDOG_CODE, 8'hff, trap code reported on a watchdog trap.

Ports:
- clk  in  1  core clock; all state updates on the falling edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  NCMT  per-lane commit valid.
- i_pc  in  NCMT*64  per-lane PC; lane n occupies bits [64n+63:64n].
- i_inst  in  NCMT*32  per-lane instruction.
- i_rd  in  NCMT*RIDX_W  per-lane destination register index.
- i_rd_wen  in  NCMT  per-lane register write enable.
- i_rd_wdata  in  NCMT*64  per-lane write data.
- i_skip  in  NCMT  per-lane skip (MMIO/CSR not comparable).
- i_a0  in  64  architectural x10 value after this cycle's commits.
- o_valid  out  NCMT  compacted commit valid; thermometer-coded (lanes 0..k-1).
- o_pc  out  NCMT*64  compacted PC.
- o_inst  out  NCMT*32  compacted instruction.
- o_wen  out  NCMT  compacted write enable.
- o_wdest  out  NCMT*8  {zero-extend, rd}.
- o_wdata  out  NCMT*64  compacted write data.
- o_skip  out  NCMT  compacted skip.
- o_trap  out  1  trap event valid; sticky once set.
- o_trap_code  out  8  trap code.
- o_trap_pc  out  64  PC of the trapping instruction, or last committed PC for a watchdog trap.
- o_cycle_cnt  out  64  cycles since reset.
- o_instr_cnt  out  64  committed instructions, skipped ones included.
- o_skip_cnt  out  64  committed instructions with skip set.

Behaviour:
- Reset: every output and internal register is 0; the FSM is in RUN; the idle counter is 0. Reset acts immediately (asynchronously), including in the middle of a trap or watchdog countdown.
- Latency: inputs sampled on falling edge N appear on the outputs after that edge, held for one full clock period.
- FSM states:
  - RUN: normal operation.
  - TRAP: terminal state; only reset leaves it.
- Lane qualification in RUN:
  - Find the lowest-indexed lane t with i_valid=1 and i_inst[6:0]==TRAP_OPC.
  - Lanes with index >t are dropped, even if valid.
  - Lane t itself is committed.
  - eff_valid = i_valid masked by that rule.
- Compaction: the j-th set bit of eff_valid, counted from lane 0, maps to output lane j. Higher output lanes have o_valid=0 and their data fields are 0. Gapped input (e.g. 4'b1010) is legal.
- Counters in RUN:
  - cycle_cnt += 1.
  - instr_cnt += popcount(eff_valid).
  - skip_cnt += popcount(eff_valid & i_skip).
  - All counters wrap modulo 2^64.
- Trap entry:
  - On a qualifying trap lane, on the same edge: o_trap=1, o_trap_code=i_a0[7:0], o_trap_pc=that lane's PC; the FSM goes to TRAP.
- Watchdog (TIMEOUT>0):
  - The idle counter resets to 0 on any edge with eff_valid!=0 and otherwise increments.
  - When it would reach TIMEOUT: o_trap=1, o_trap_code=WDOG_CODE, o_trap_pc=last committed PC (0 if none yet); the FSM goes to TRAP.
  - A real trap and a watchdog expiry on the same edge: the real trap wins.
- In TRAP:
  - o_valid is forced to 0 from the next edge on.
  - All counters and trap fields hold.
  - Inputs are ignored.
- Only lane 0 to lane NCMT-1 are ever used; NCMT=1 degenerates to a single-lane commit unit with no compaction.

Decomposition:
- Shared package/defines: the trap opcode, watchdog code, record field widths, and the FSM state encoding (RUN=0, TRAP=1).
- One sub-module, cmt_compact: combinational NCMT-lane priority compactor producing lane select indices. It is reused for the trap mask (prefix-OR).
- Popcount is local to cmt_multi.

Test Plan:
- NCMT=2, inputs i_valid=2'b11, PCs 0x80000000 and 0x80000004, lane 1 writes x5=0x1234 -> next edge: o_valid=2'b11, o_wdest[15:8]=8'h05, instr_cnt=2, cycle_cnt=1.
- NCMT=4, i_valid=4'b1010, PCs 0x100 on lane 1 and 0x200 on lane 3 -> o_valid=4'b0011, o_pc lane0=0x100, lane1=0x200, lanes 2-3 all zero.
- NCMT=2, both lanes valid, lane 0 inst=0x0000006b, i_a0=0 -> o_trap=1, code=0, trap_pc=lane0 PC, o_valid=2'b01, instr_cnt+=1. All following cycles: o_valid=0 and counters frozen.
- TIMEOUT=8, one commit then 8 idle cycles -> o_trap=1, code=8'hff, trap_pc=that commit's PC. A trap instruction presented on the expiring edge instead yields code=i_a0[7:0].
- Skip accounting: 3 commits with i_skip=1 out of 5 -> instr_cnt=5, skip_cnt=3, o_skip mirrors the compacted lanes.
- Assert rst mid-run and in TRAP, between clock edges -> all outputs read 0 immediately without waiting for an edge; after release, commits resume from state RUN with cycle_cnt restarting at 1.
